// File: rtl/dm_golden_checker_pkg.sv
// Shared types and default constants for the data-memory golden checker.
package chk_pkg;

  // Checker phases: snooping the program run, scanning DM, finished.
  typedef enum logic [1:0] {
    CHK_RUN  = 2'd0,
    CHK_SCAN = 2'd1,
    CHK_DONE = 2'd2
  } chk_state_t;

  // Default simulation end-marker location/value and start of the result window.
  localparam int          SIM_END_ADDR = 'h3fff;
  localparam logic [31:0] SIM_END_CODE = 32'hffffffff;
  localparam int          TEST_START   = 'h2000;

endpackage

// File: rtl/dm_golden_checker_if.sv
// Bundle of DM snoop, DM read-back, golden ROM and result signals of the checker.
// master = checker side, slave = memories/environment side.
interface dm_golden_checker_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 14,
  parameter int ERR_W  = 16
) ();
  logic [3:0]        dm_web;
  logic [ADDR_W-1:0] dm_waddr;
  logic [DATA_W-1:0] dm_wdata;
  logic              chk_re;
  logic [ADDR_W-1:0] chk_raddr;
  logic [DATA_W-1:0] chk_rdata;
  logic [ADDR_W-1:0] gold_addr;
  logic [DATA_W-1:0] gold_rdata;
  logic              mis_valid;
  logic [ADDR_W-1:0] mis_addr;
  logic [DATA_W-1:0] mis_got;
  logic [DATA_W-1:0] mis_exp;
  logic              done;
  logic              pass;
  logic              timeout;
  logic [ERR_W-1:0]  err_count;

  modport master (
    input  dm_web, dm_waddr, dm_wdata, chk_rdata, gold_rdata,
    output chk_re, chk_raddr, gold_addr, mis_valid, mis_addr, mis_got, mis_exp,
           done, pass, timeout, err_count
  );

  modport slave (
    output dm_web, dm_waddr, dm_wdata, chk_rdata, gold_rdata,
    input  chk_re, chk_raddr, gold_addr, mis_valid, mis_addr, mis_got, mis_exp,
           done, pass, timeout, err_count
  );
endinterface

// File: rtl/dm_golden_checker_sat_counter.sv
// Saturating up-counter: holds at all-ones instead of wrapping.
module chk_sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_clr,
  input  logic         i_inc,
  output logic [W-1:0] o_count
);
  logic [W-1:0] r_count;

  // Count up on i_inc, stick at the maximum value, clear on i_clr or reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_inc && (r_count != {W{1'b1}})) begin
      r_count <= r_count + W'(1);
    end
  end

  assign o_count = r_count;
endmodule

// File: rtl/dm_golden_checker.sv
// Self-check engine: waits for the end marker (or a cycle budget), then compares a
// window of DM words against a golden ROM and reports mismatches and a verdict.
module dm_golden_checker #(
  parameter int                DATA_W     = 32,
  parameter int                ADDR_W     = 14,
  parameter int                TEST_START = chk_pkg::TEST_START,
  parameter int                NUM_WORDS  = 64,
  parameter int                END_ADDR   = chk_pkg::SIM_END_ADDR,
  parameter logic [DATA_W-1:0] END_CODE   = DATA_W'(chk_pkg::SIM_END_CODE),
  parameter int                MAX_CYCLES = 100000,
  parameter int                ERR_W      = 16
) (
  input logic                 clk,
  input logic                 rst,
  dm_golden_checker_if.master bus
);
  import chk_pkg::*;

  localparam int CYC_W = $clog2(MAX_CYCLES);
  localparam int IDX_W = $clog2(NUM_WORDS + 1);

  chk_state_t        r_state;
  logic [CYC_W-1:0]  r_cyc;
  logic [IDX_W-1:0]  r_idx;
  logic              r_done;
  logic              r_timeout;
  logic              r_cmp_valid;
  logic [ADDR_W-1:0] r_cmp_addr;
  logic [ERR_W-1:0]  w_err_count;

  logic              w_marker;
  logic              w_expired;
  logic              w_issue;
  logic              w_last;
  logic              w_mismatch;
  logic [ADDR_W-1:0] w_issue_addr;

  // Only a full-word write of the exact code to the marker address ends the run.
  assign w_marker  = (bus.dm_web == 4'hf) && (bus.dm_waddr == ADDR_W'(END_ADDR))
                     && (bus.dm_wdata == END_CODE);
  assign w_expired = (r_cyc == CYC_W'(MAX_CYCLES - 1));

  // Issue stage runs for NUM_WORDS cycles; the extra final cycle only compares.
  assign w_issue      = (r_state == CHK_SCAN) && (r_idx < IDX_W'(NUM_WORDS));
  assign w_last       = (r_state == CHK_SCAN) && (r_idx == IDX_W'(NUM_WORDS));
  assign w_issue_addr = ADDR_W'(TEST_START) + ADDR_W'(r_idx);
  assign w_mismatch   = r_cmp_valid && (bus.chk_rdata != bus.gold_rdata);

  // Phase sequencing, run-phase cycle budget and scan index.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= CHK_RUN;
      r_cyc     <= '0;
      r_idx     <= '0;
      r_done    <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      case (r_state)
        CHK_RUN: begin
          r_cyc <= r_cyc + CYC_W'(1);
          if (w_marker) begin
            r_state <= CHK_SCAN;
          end else if (w_expired) begin
            r_state   <= CHK_SCAN;
            r_timeout <= 1'b1;
          end
        end
        CHK_SCAN: begin
          if (w_last) begin
            r_state <= CHK_DONE;
            r_done  <= 1'b1;
          end else begin
            r_idx <= r_idx + IDX_W'(1);
          end
        end
        CHK_DONE: begin
          r_state <= CHK_DONE;
        end
        default: begin
          r_state <= CHK_RUN;
        end
      endcase
    end
  end

  // Issue-to-compare pipeline register: remembers which DM address is being returned.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cmp_valid <= 1'b0;
      r_cmp_addr  <= '0;
    end else begin
      r_cmp_valid <= w_issue;
      r_cmp_addr  <= w_issue ? w_issue_addr : '0;
    end
  end

  chk_sat_counter #(
    .W(ERR_W)
  ) u_err_cnt (
    .clk    (clk),
    .rst    (rst),
    .i_clr  (1'b0),
    .i_inc  (w_mismatch),
    .o_count(w_err_count)
  );

  // Read requests are driven only while issuing so idle outputs read as zero.
  assign bus.chk_re    = w_issue;
  assign bus.chk_raddr = w_issue ? w_issue_addr : '0;
  assign bus.gold_addr = w_issue ? ADDR_W'(r_idx) : '0;

  assign bus.mis_valid = w_mismatch;
  assign bus.mis_addr  = w_mismatch ? r_cmp_addr : '0;
  assign bus.mis_got   = w_mismatch ? bus.chk_rdata : '0;
  assign bus.mis_exp   = w_mismatch ? bus.gold_rdata : '0;

  assign bus.done      = r_done;
  assign bus.timeout   = r_timeout;
  assign bus.err_count = w_err_count;
  assign bus.pass      = r_done && (w_err_count == '0) && !r_timeout;
endmodule
